// File: rtl/rotary_step_sched_if.sv
// rotary_step_sched_if: encoder/switch pins and LED/status outputs of rotary_step_sched.
// With ROTARY_CENTER_EN defined the encoder push-button line rot_center is added.
interface rotary_step_sched_if;
    logic       rot_a;
    logic       rot_b;
    logic       invert;
`ifdef ROTARY_CENTER_EN
    logic       rot_center;
`endif
    logic [7:0] led_out;
    logic [3:0] pending;
    logic       step_cw;
    logic       step_ccw;
    logic       drop;

    // Board / stimulus side: drives the pins, observes the controller outputs.
    modport master (
        output rot_a, rot_b, invert,
`ifdef ROTARY_CENTER_EN
        output rot_center,
`endif
        input  led_out, pending, step_cw, step_ccw, drop
    );

    // Controller side.
    modport slave (
        input  rot_a, rot_b, invert,
`ifdef ROTARY_CENTER_EN
        input  rot_center,
`endif
        output led_out, pending, step_cw, step_ccw, drop
    );
endinterface

// File: rtl/rotary_step_sched.sv
// rotary_step_sched: synchronises and debounces a quadrature encoder, decodes whole detent
// clicks into CW/CCW events, buffers them in a saturating signed counter and releases them
// at a fixed pace onto a one-hot LED rotation register.
// Optional feature macro: ROTARY_CENTER_EN (encoder push-button press recentres the display).
module rotary_step_sched #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned STEP_DIV        = 25000000,
    parameter int unsigned PEND_MAX        = 7
) (
    input logic                clk,
    input logic                rst_n,
    rotary_step_sched_if.slave io_bus
);

`ifdef ROTARY_CENTER_EN
    localparam int unsigned NL = 3;
`else
    localparam int unsigned NL = 2;
`endif
    localparam int unsigned     DBW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned     TW        = $clog2(STEP_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic signed [4:0] PMAX    = 5'(PEND_MAX);
    localparam logic signed [4:0] PMIN    = -PMAX;

    typedef enum logic [2:0] {
        StRest, StCw1, StCw2, StCw3, StCcw1, StCcw2, StCcw3, StErr
    } dec_state_e;

    // Line index: 0 = A, 1 = B, 2 = center press (optional).
    logic [NL-1:0]   w_raw;
    logic [NL-1:0]   r_sync1;
    logic [NL-1:0]   r_sync2;
    logic [NL-1:0]   r_filt;
    logic [DBW-1:0]  r_db_cnt [NL];
    logic            r_inv_s1;
    logic            r_inv_s2;

    dec_state_e      r_state;
    dec_state_e      w_state_next;
    logic [1:0]      w_ab;
    logic            w_ev_cw;
    logic            w_ev_ccw;
    logic            r_ev_cw;
    logic            r_ev_ccw;

    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;

    logic signed [3:0] r_pending;
    logic [7:0]        r_q;
    logic              r_step_cw;
    logic              r_step_ccw;
    logic              r_drop;
    logic signed [4:0] w_pend_ext;
    logic signed [4:0] w_base;
    logic signed [4:0] w_cand;
    logic signed [4:0] w_pend_next;
    logic [7:0]        w_q_next;
    logic              w_tick_pos;
    logic              w_tick_neg;
    logic              w_drop;
    logic              w_press;

`ifdef ROTARY_CENTER_EN
    assign w_raw = {io_bus.rot_center, io_bus.rot_b, io_bus.rot_a};
`else
    assign w_raw = {io_bus.rot_b, io_bus.rot_a};
`endif

    // Two-flop synchronisers for the encoder lines and the invert switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_inv_s1 <= 1'b0;
            r_inv_s2 <= 1'b0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_inv_s1 <= io_bus.invert;
            r_inv_s2 <= r_inv_s1;
        end
    end

    // Per-line debounce: filtered level follows only after DEBOUNCE_CYCLES differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            for (int i = 0; i < NL; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_filt[i]   <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef ROTARY_CENTER_EN
    logic r_press_prev;

    // Previous filtered press level, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_press_prev <= 1'b0;
        else        r_press_prev <= r_filt[2];
    end

    assign w_press = r_filt[2] & ~r_press_prev;
`else
    assign w_press = 1'b0;
`endif

    assign w_ab = {r_filt[0], r_filt[1]};

    // Decoder state register; registered one-cycle event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StRest;
            r_ev_cw  <= 1'b0;
            r_ev_ccw <= 1'b0;
        end else if (w_press) begin
            r_state  <= StRest;
            r_ev_cw  <= 1'b0;
            r_ev_ccw <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ev_cw  <= w_ev_cw;
            r_ev_ccw <= w_ev_ccw;
        end
    end

    // Decoder next state: the expected next code advances, the current code holds,
    // 00 returns to rest and anything else is an error until 00 is seen.
    always_comb begin
        w_state_next = r_state;
        w_ev_cw      = 1'b0;
        w_ev_ccw     = 1'b0;
        unique case (r_state)
            StRest: begin
                case (w_ab)
                    2'b10:   w_state_next = StCw1;
                    2'b01:   w_state_next = StCcw1;
                    2'b11:   w_state_next = StErr;
                    default: w_state_next = StRest;
                endcase
            end
            StCw1: begin
                if (w_ab == 2'b00)      w_state_next = StRest;
                else if (w_ab == 2'b11) w_state_next = StCw2;
                else if (w_ab != 2'b10) w_state_next = StErr;
            end
            StCw2: begin
                if (w_ab == 2'b00)      w_state_next = StRest;
                else if (w_ab == 2'b01) w_state_next = StCw3;
                else if (w_ab != 2'b11) w_state_next = StErr;
            end
            StCw3: begin
                if (w_ab == 2'b00) begin
                    w_state_next = StRest;
                    w_ev_cw      = 1'b1;
                end else if (w_ab != 2'b01) begin
                    w_state_next = StErr;
                end
            end
            StCcw1: begin
                if (w_ab == 2'b00)      w_state_next = StRest;
                else if (w_ab == 2'b11) w_state_next = StCcw2;
                else if (w_ab != 2'b01) w_state_next = StErr;
            end
            StCcw2: begin
                if (w_ab == 2'b00)      w_state_next = StRest;
                else if (w_ab == 2'b10) w_state_next = StCcw3;
                else if (w_ab != 2'b11) w_state_next = StErr;
            end
            StCcw3: begin
                if (w_ab == 2'b00) begin
                    w_state_next = StRest;
                    w_ev_ccw     = 1'b1;
                end else if (w_ab != 2'b10) begin
                    w_state_next = StErr;
                end
            end
            StErr: begin
                if (w_ab == 2'b00) w_state_next = StRest;
            end
            default: w_state_next = StRest;
        endcase
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running scheduler tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_tick_cnt <= '0;
        else if (w_press || w_tick) r_tick_cnt <= '0;
        else                      r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    // Tick consumption first, then the event; saturation is judged on that net result.
    always_comb begin
        w_pend_ext = {r_pending[3], r_pending};
        w_tick_pos = w_tick && (r_pending > 4'sd0);
        w_tick_neg = w_tick && (r_pending < 4'sd0);
        w_base     = w_pend_ext;
        w_q_next   = r_q;
        if (w_tick_pos) begin
            w_base   = w_pend_ext - 5'sd1;
            w_q_next = {r_q[6:0], r_q[7]};
        end else if (w_tick_neg) begin
            w_base   = w_pend_ext + 5'sd1;
            w_q_next = {r_q[0], r_q[7:1]};
        end
        w_cand = w_base;
        if (r_ev_cw)       w_cand = w_base + 5'sd1;
        else if (r_ev_ccw) w_cand = w_base - 5'sd1;
        w_drop      = (w_cand > PMAX) || (w_cand < PMIN);
        w_pend_next = w_drop ? w_base : w_cand;
    end

    // Pending counter, rotation register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 4'sd0;
            r_q        <= 8'h01;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_drop     <= 1'b0;
        end else if (w_press) begin
            r_pending  <= 4'sd0;
            r_q        <= 8'h01;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_pending  <= $signed(w_pend_next[3:0]);
            r_q        <= w_q_next;
            r_step_cw  <= w_tick_pos;
            r_step_ccw <= w_tick_neg;
            r_drop     <= w_drop;
        end
    end

    assign io_bus.led_out  = r_inv_s2 ? ~r_q : r_q;
    assign io_bus.pending  = r_pending;
    assign io_bus.step_cw  = r_step_cw;
    assign io_bus.step_ccw = r_step_ccw;
    assign io_bus.drop     = r_drop;

endmodule
